// File: rtl/d8m_pkg.sv
// d8m_pkg: shared types and constants for the synthetic D8M frame generator.
//   state_t   - frame sequencer states
//   pattern_t - test-pattern selector codes
//   LFSR seed/taps and a step helper for the optional noise pattern
package d8m_pkg;

  localparam int D8M_DATA_W = 12;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    V_BLANK = 3'd1,
    F_LEAD  = 3'd2,
    ACTIVE  = 3'd3,
    H_BLANK = 3'd4,
    F_TAIL  = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    PAT_HRAMP   = 2'd0,
    PAT_VRAMP   = 2'd1,
    PAT_CHECKER = 2'd2,
    PAT_SUM     = 2'd3
  } pattern_t;

  localparam logic [D8M_DATA_W-1:0] LFSR_SEED = 12'hACE;
  // x^12 + x^6 + x^4 + x + 1 -> feedback from bits 11, 5, 3, 0
  localparam logic [D8M_DATA_W-1:0] LFSR_TAPS = 12'h829;

  function automatic logic [D8M_DATA_W-1:0] lfsr_next(input logic [D8M_DATA_W-1:0] cur);
    return {cur[D8M_DATA_W-2:0], ^(cur & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/d8m_frame_gen_if.sv
// d8m_frame_gen_if: video bus between the frame generator and the camera
// write/counter path.
//   oFVAL, oLVAL       - frame / line valid
//   oDATA              - 12-bit pixel, valid while oLVAL = 1
//   oX_Cont, oY_Cont   - active pixel / line index
// Modports: master (generator side), slave (consumer side).
interface d8m_frame_gen_if;
  import d8m_pkg::*;

  logic                  oFVAL;
  logic                  oLVAL;
  logic [D8M_DATA_W-1:0] oDATA;
  logic [15:0]           oX_Cont;
  logic [15:0]           oY_Cont;

  modport master (output oFVAL, output oLVAL, output oDATA, output oX_Cont, output oY_Cont);
  modport slave  (input  oFVAL, input  oLVAL, input  oDATA, input  oX_Cont, input  oY_Cont);
endinterface

// File: rtl/d8m_pattern_src.sv
// d8m_pattern_src: combinational test-pattern generator; the parent registers data.
//   clk, rst     - clock / async active-high reset (LFSR only)
//   x, y         - pixel and line index of the pixel being produced
//   pattern      - pattern latched for the current frame
//   active       - a pixel is being produced this clock (LFSR advances)
//   frame_start  - F_LEAD is being entered (LFSR reseeds)
//   data         - pixel value
// Build option D8M_FRAME_GEN_LFSR_EN turns pattern 3 into a 12-bit LFSR.
module d8m_pattern_src
  import d8m_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [15:0]           x,
  input  logic [15:0]           y,
  input  pattern_t              pattern,
  input  logic                  active,
  input  logic                  frame_start,
  output logic [D8M_DATA_W-1:0] data
);

  logic [D8M_DATA_W-1:0] noise;
  logic                  unused_bits;

`ifdef D8M_FRAME_GEN_LFSR_EN
  logic [D8M_DATA_W-1:0] lfsr_q;

  // Current value is emitted, then the register steps for the next pixel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              lfsr_q <= LFSR_SEED;
    else if (frame_start) lfsr_q <= LFSR_SEED;
    else if (active)      lfsr_q <= lfsr_next(lfsr_q);
  end

  assign noise       = lfsr_q;
  assign unused_bits = ^{x[15:D8M_DATA_W], y[15:D8M_DATA_W]};
`else
  assign noise       = x[D8M_DATA_W-1:0] + y[D8M_DATA_W-1:0];
  assign unused_bits = ^{clk, rst, active, frame_start, x[15:D8M_DATA_W], y[15:D8M_DATA_W]};
`endif

  always_comb begin
    data = '0;
    case (pattern)
      PAT_HRAMP:   data = x[D8M_DATA_W-1:0];
      PAT_VRAMP:   data = y[D8M_DATA_W-1:0];
      PAT_CHECKER: data = (x[3] ^ y[3]) ? '1 : '0;
      PAT_SUM:     data = noise;
      default:     data = '0;
    endcase
  end

endmodule

// File: rtl/d8m_frame_gen.sv
// d8m_frame_gen: synthetic D8M-style sensor source for bring-up/regression.
//   iCLK, iRST   - pixel clock, async active-high reset
//   iEN          - run request, sampled only at frame boundaries
//   iPATTERN     - test pattern, latched on entry to F_LEAD
//   vid          - video bus (FVAL, LVAL, DATA, X/Y counters), master side
//   oFRAME_CNT   - completed-frame count (wraps)
//   oBUSY        - high whenever the sequencer is not IDLE
// Build option D8M_FRAME_GEN_LFSR_EN: pattern 3 is a reseeded LFSR.
//
// state   | meaning
// IDLE    | stopped, waiting for iEN
// V_BLANK | FVAL low for V_BLANK_LINES line periods
// F_LEAD  | FVAL high, LVAL low before the first line
// ACTIVE  | FVAL/LVAL high, one pixel per clock
// H_BLANK | FVAL high, LVAL low, rest of the line period
// F_TAIL  | FVAL high, LVAL low after the last line
module d8m_frame_gen
  import d8m_pkg::*;
#(
  parameter int H_ACTIVE      = 640,
  parameter int LINE_CNT      = 792,
  parameter int V_ACTIVE      = 480,
  parameter int V_BLANK_LINES = 4,
  parameter int FVAL_LEAD     = 16,
  parameter int FVAL_TAIL     = 16
) (
  input  logic               iCLK,
  input  logic               iRST,
  input  logic               iEN,
  input  logic [1:0]         iPATTERN,
  d8m_frame_gen_if.master    vid,
  output logic [15:0]        oFRAME_CNT,
  output logic               oBUSY
);

  localparam int TMR_W   = 32;
  localparam int VB_CLKS = V_BLANK_LINES * LINE_CNT;

  state_t                state_q, state_d;
  logic [TMR_W-1:0]      tmr_q, tmr_d;
  logic [15:0]           x_q, x_d, y_q, y_d, fc_q, fc_d;
  pattern_t              pat_q;
  logic                  fval_q, lval_q, busy_q, tc, frame_start;
  logic [D8M_DATA_W-1:0] data_q, pat_data;

  assign tc = (tmr_q == '0);

  // Each state loads the down-counter with its length minus one on entry
  // and leaves on terminal count.
  always_comb begin
    state_d     = state_q;
    tmr_d       = tc ? '0 : tmr_q - 1'b1;
    x_d         = '0;
    y_d         = y_q;
    fc_d        = fc_q;
    frame_start = 1'b0;
    case (state_q)
      IDLE: begin
        if (iEN) begin
          state_d = V_BLANK;
          tmr_d   = TMR_W'(VB_CLKS - 1);
        end
      end
      V_BLANK: begin
        if (tc) begin
          state_d     = F_LEAD;
          tmr_d       = TMR_W'(FVAL_LEAD - 1);
          frame_start = 1'b1;
        end
      end
      F_LEAD: begin
        if (tc) begin
          state_d = ACTIVE;
          tmr_d   = TMR_W'(H_ACTIVE - 1);
        end
      end
      ACTIVE: begin
        if (tc) begin
          state_d = H_BLANK;
          tmr_d   = TMR_W'(LINE_CNT - H_ACTIVE - 1);
        end
      end
      H_BLANK: begin
        if (tc) begin
          y_d = y_q + 16'd1;
          if (y_q == 16'(V_ACTIVE - 1)) begin
            state_d = F_TAIL;
            tmr_d   = TMR_W'(FVAL_TAIL - 1);
          end else begin
            state_d = ACTIVE;
            tmr_d   = TMR_W'(H_ACTIVE - 1);
          end
        end
      end
      F_TAIL: begin
        if (tc) begin
          fc_d = fc_q + 16'd1;
          if (iEN) begin
            state_d = V_BLANK;
            tmr_d   = TMR_W'(VB_CLKS - 1);
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // X counts only across a line; it parks at 0 in every blanking interval.
    if (state_d == ACTIVE && state_q == ACTIVE) x_d = x_q + 16'd1;
    if (state_d == IDLE || state_d == V_BLANK) y_d = '0;
  end

  d8m_pattern_src u_pattern (
    .clk         (iCLK),
    .rst         (iRST),
    .x           (x_d),
    .y           (y_d),
    .pattern     (pat_q),
    .active      (state_d == ACTIVE),
    .frame_start (frame_start),
    .data        (pat_data)
  );

  // Outputs are registered from next-state values so every bus field
  // changes on the same edge as the state.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q <= IDLE;
      tmr_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      fc_q    <= '0;
      pat_q   <= PAT_HRAMP;
      fval_q  <= 1'b0;
      lval_q  <= 1'b0;
      busy_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      x_q     <= x_d;
      y_q     <= y_d;
      fc_q    <= fc_d;
      if (frame_start) pat_q <= pattern_t'(iPATTERN);
      fval_q  <= (state_d == F_LEAD) || (state_d == ACTIVE) ||
                 (state_d == H_BLANK) || (state_d == F_TAIL);
      lval_q  <= (state_d == ACTIVE);
      busy_q  <= (state_d != IDLE);
      data_q  <= (state_d == ACTIVE) ? pat_data : '0;
    end
  end

  assign vid.oFVAL   = fval_q;
  assign vid.oLVAL   = lval_q;
  assign vid.oDATA   = data_q;
  assign vid.oX_Cont = x_q;
  assign vid.oY_Cont = y_q;
  assign oFRAME_CNT  = fc_q;
  assign oBUSY       = busy_q;

endmodule

// File: tb/tb_d8m_frame_gen.sv
// tb_d8m_frame_gen: self-checking bench for d8m_frame_gen using small frame
// parameters (36-clock frame). A frame-time reference model predicts every
// output each clock; a vector table and hand sequences cover the corners.
module tb_d8m_frame_gen;
  import d8m_pkg::*;

  localparam int H    = 4;
  localparam int LC   = 8;
  localparam int VA   = 3;
  localparam int VBL  = 1;
  localparam int LEAD = 2;
  localparam int TAIL = 2;
  localparam int VB   = VBL * LC;
  localparam int FR   = VB + LEAD + VA * LC + TAIL;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b0;
  logic [1:0] pat = 2'd0;
  logic [15:0] fc;
  logic        busy;

  d8m_frame_gen_if vid();

  d8m_frame_gen #(
    .H_ACTIVE(H), .LINE_CNT(LC), .V_ACTIVE(VA),
    .V_BLANK_LINES(VBL), .FVAL_LEAD(LEAD), .FVAL_TAIL(TAIL)
  ) dut (
    .iCLK(clk), .iRST(rst), .iEN(en), .iPATTERN(pat),
    .vid(vid), .oFRAME_CNT(fc), .oBUSY(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 30)
        $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [11:0] lfsr_step(input logic [11:0] v);
    return {v[10:0], v[11] ^ v[5] ^ v[3] ^ v[0]};
  endfunction

  // Reference model: position in the frame as a single clock index.
  bit          m_run  = 1'b0;
  int          m_t    = 0;
  logic [1:0]  m_pat  = 2'd0;
  logic [15:0] m_fc   = 16'd0;
  logic [11:0] m_lfsr = 12'hACE;
  logic        e_fval = 1'b0, e_lval = 1'b0, e_busy = 1'b0, e_xy_ok = 1'b0;
  logic [11:0] e_data = 12'd0;
  logic [15:0] e_x = 16'd0, e_y = 16'd0;

  always @(posedge clk or posedge rst) begin
    int u;
    logic [11:0] s;
    if (rst) begin
      m_run = 1'b0; m_t = 0; m_pat = 2'd0; m_fc = 16'd0; m_lfsr = 12'hACE;
    end else begin
      if (!m_run) begin
        if (en) begin m_run = 1'b1; m_t = 0; end
      end else if (m_t == FR - 1) begin
        m_fc = m_fc + 16'd1;
        if (en) m_t = 0; else m_run = 1'b0;
      end else begin
        m_t++;
      end
      if (m_run && m_t == VB) begin m_pat = pat; m_lfsr = 12'hACE; end
    end
    e_fval = 1'b0; e_lval = 1'b0; e_data = 12'd0; e_x = 16'd0; e_y = 16'd0;
    e_xy_ok = 1'b0; e_busy = m_run;
    if (m_run) begin
      if (m_t < VB) e_xy_ok = 1'b1;
      else begin
        e_fval = 1'b1;
        if (m_t == VB) e_xy_ok = 1'b1;
        if (m_t >= VB + LEAD && m_t < VB + LEAD + VA * LC) begin
          u = m_t - VB - LEAD;
          if (u % LC < H) begin
            e_lval = 1'b1; e_xy_ok = 1'b1;
            e_x = 16'(u % LC); e_y = 16'(u / LC);
            s = e_x[11:0] + e_y[11:0];
            case (m_pat)
              2'd0: e_data = e_x[11:0];
              2'd1: e_data = e_y[11:0];
              2'd2: e_data = (e_x[3] ^ e_y[3]) ? 12'hFFF : 12'h000;
              default: begin
`ifdef D8M_FRAME_GEN_LFSR_EN
                e_data = m_lfsr; m_lfsr = lfsr_step(m_lfsr);
`else
                e_data = s;
`endif
              end
            endcase
          end
        end
      end
    end
  end

  bit chk_on = 1'b0;
  always @(negedge clk) begin
    if (chk_on) begin
      check("model_fval", 32'(vid.oFVAL), 32'(e_fval));
      check("model_lval", 32'(vid.oLVAL), 32'(e_lval));
      check("model_data", 32'(vid.oDATA), 32'(e_data));
      check("model_busy", 32'(busy), 32'(e_busy));
      check("model_fcnt", 32'(fc), 32'(m_fc));
      if (e_xy_ok) begin
        check("model_x", 32'(vid.oX_Cont), 32'(e_x));
        check("model_y", 32'(vid.oY_Cont), 32'(e_y));
      end
    end
  end

  int   n_rise = 0, n_pulse = 0;
  logic p_f = 1'b0, p_l = 1'b0;
  always @(negedge clk) begin
    if (vid.oFVAL && !p_f) n_rise++;
    if (vid.oLVAL && !p_l) n_pulse++;
    p_f = vid.oFVAL;
    p_l = vid.oLVAL;
  end

  typedef struct {
    logic [1:0]  pat;
    int          frames;
    logic [15:0] fc;
    int          rises;
    int          pulses;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int base_r, base_p, got, n;
    logic [15:0] fc0;
    logic [11:0] buf_d[24];

    vecs[0] = '{pat: 2'd0, frames: 1, fc: 16'd1, rises: 1, pulses: 3};
    vecs[1] = '{pat: 2'd1, frames: 2, fc: 16'd3, rises: 2, pulses: 6};
    vecs[2] = '{pat: 2'd2, frames: 1, fc: 16'd4, rises: 1, pulses: 3};
    vecs[3] = '{pat: 2'd3, frames: 3, fc: 16'd7, rises: 3, pulses: 9};

    repeat (3) @(negedge clk);
    check("rst_fval", 32'(vid.oFVAL), 32'd0);
    check("rst_lval", 32'(vid.oLVAL), 32'd0);
    check("rst_data", 32'(vid.oDATA), 32'd0);
    check("rst_x", 32'(vid.oX_Cont), 32'd0);
    check("rst_y", 32'(vid.oY_Cont), 32'd0);
    check("rst_fcnt", 32'(fc), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    chk_on = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      base_r = n_rise; base_p = n_pulse;
      pat = vecs[i].pat; en = 1'b1;
      repeat (FR * vecs[i].frames) @(negedge clk);
      en = 1'b0;
      repeat (4) @(negedge clk);
      check("tbl_fcnt", 32'(fc), 32'(vecs[i].fc));
      check("tbl_busy", 32'(busy), 32'd0);
      check("tbl_fval_rises", 32'(n_rise - base_r), 32'(vecs[i].rises));
      check("tbl_lval_pulses", 32'(n_pulse - base_p), 32'(vecs[i].pulses));
    end

`ifdef D8M_FRAME_GEN_LFSR_EN
    pat = 2'd3; en = 1'b1; got = 0;
    for (int c = 0; c < 4 * FR && got < 24; c++) begin
      @(negedge clk);
      if (vid.oLVAL) begin buf_d[got] = vid.oDATA; got++; end
    end
    check("lfsr_pixels_seen", 32'(got), 32'd24);
    check("lfsr_first", 32'(buf_d[0]), 32'h0ACE);
    check("lfsr_second", 32'(buf_d[1]), 32'(lfsr_step(12'hACE)));
    for (int k = 0; k < 12; k++) check("lfsr_repeat", 32'(buf_d[k + 12]), 32'(buf_d[k]));
`else
    pat = 2'd3; en = 1'b1; got = 0;
    for (int c = 0; c < 3 * FR && got < 4; c++) begin
      @(negedge clk);
      if (vid.oLVAL && vid.oY_Cont == 16'd2) begin buf_d[got] = vid.oDATA; got++; end
    end
    check("sum_pixels_seen", 32'(got), 32'd4);
    for (int k = 0; k < 4; k++) check("sum_line2", 32'(buf_d[k]), 32'(k + 2));
`endif
    en = 1'b0;
    got = 0;
    for (int c = 0; c < 3 * FR; c++) begin
      @(negedge clk);
      if (!busy) begin got = 1; break; end
    end
    check("pat3_reach_idle", 32'(got), 32'd1);

    // iEN drop and pattern change in line 1 must not affect the frame.
    @(negedge clk);
    fc0 = fc; pat = 2'd0; en = 1'b1; got = 0;
    for (int c = 0; c < 2 * FR; c++) begin
      @(negedge clk);
      if (vid.oLVAL && vid.oY_Cont == 16'd1) begin got = 1; break; end
    end
    check("mid_reach_line1", 32'(got), 32'd1);
    en = 1'b0; pat = 2'd2; got = 0;
    for (int c = 0; c < 2 * FR; c++) begin
      @(negedge clk);
      if (vid.oLVAL) check("mid_data_hramp", 32'(vid.oDATA), 32'(vid.oX_Cont[11:0]));
      if (!busy) begin got = 1; break; end
    end
    check("mid_reach_idle", 32'(got), 32'd1);
    check("mid_fcnt", 32'(fc), 32'(fc0 + 16'd1));
    base_r = n_rise;
    repeat (100) @(negedge clk);
    check("mid_no_new_fval", 32'(n_rise - base_r), 32'd0);
    check("mid_busy", 32'(busy), 32'd0);

    // Reset while LVAL is high.
    pat = 2'd1; en = 1'b1; got = 0;
    for (int c = 0; c < 2 * FR; c++) begin
      @(negedge clk);
      if (vid.oLVAL) begin got = 1; break; end
    end
    check("rst_reach_lval", 32'(got), 32'd1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("rstmid_fval", 32'(vid.oFVAL), 32'd0);
    check("rstmid_lval", 32'(vid.oLVAL), 32'd0);
    check("rstmid_data", 32'(vid.oDATA), 32'd0);
    check("rstmid_fcnt", 32'(fc), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      n++;
      if (vid.oFVAL) break;
    end
    check("rst_fval_delay", 32'(n - 1), 32'd8);

    // Random run-request, pattern and occasional reset traffic.
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 49) == 0) en = ~en;
      if ($urandom_range(0, 9) == 0) pat = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 699) == 0) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
    end
    en = 1'b0;
    @(negedge clk);
    chk_on = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
